// File: rtl/combo_pkg.sv
// Shared definitions for the combination-lock front end: FSM state
// encodings, default combo width/value and a small sizing helper.
package combo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_HOLD     = 3'd3,
        ST_COOLDOWN = 3'd4
    } state_t;

    localparam int         COMBO_WIDTH = 4;
    localparam logic [3:0] COMBO_RESET = 4'b0110;

    // Counter width able to hold 0..n-1 for the larger of two cycle counts.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for one raw active-low push-button, followed by
// inversion so the output reads 1 while the key is pressed.
module key_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_pressed
);

    logic r_s1;
    logic r_s2;

    // Resync the asynchronous key level; reset to "released".
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_key_n;
            r_s2 <= r_s1;
        end
    end

    assign o_pressed = ~r_s2;

endmodule

// File: rtl/combo_key_ctrl.sv
// Front-end controller for the combination lock: synchronises and debounces
// the enter/change keys, emits single-cycle pulses, snapshots the switch
// code on each accepted press and owns the stored combo.
// Optional macro COMBO_ATTEMPT_CNT_EN adds a saturating failed-attempt
// counter output (fail_cnt).
module combo_key_ctrl
    import combo_pkg::*;
#(
    parameter int               WIDTH        = COMBO_WIDTH,
    parameter logic [WIDTH-1:0] RESET_COMBO  = WIDTH'(COMBO_RESET),
    parameter int               DEBOUNCE_CYC = 500000,
    parameter int               HOLDOFF_CYC  = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] SW,
    input  logic             KEY_enter_n,
    input  logic             KEY_change_n,
    input  logic             set,
    output logic             enter,
    output logic             change,
    output logic             isCombo,
    output logic             busy
`ifdef COMBO_ATTEMPT_CNT_EN
    ,output logic [7:0]      fail_cnt
`endif
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYC, HOLDOFF_CYC);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HLD_LAST = CNT_W'(HOLDOFF_CYC - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_key;      // 1 = change key owns this press
    logic             w_key_nxt;
    logic [WIDTH-1:0] r_code;
    logic [WIDTH-1:0] r_stored;
    logic             w_pe;
    logic             w_pc;
    logic             w_sel;
    logic             w_snap;

    key_sync u_sync_enter (
        .i_clk     (Clock),
        .i_rst_n   (Resetn),
        .i_key_n   (KEY_enter_n),
        .o_pressed (w_pe)
    );

    key_sync u_sync_change (
        .i_clk     (Clock),
        .i_rst_n   (Resetn),
        .i_key_n   (KEY_change_n),
        .o_pressed (w_pc)
    );

    assign w_sel = r_key ? w_pc : w_pe;

    // FSM state, shared counter and selected-key register.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_key   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_key   <= w_key_nxt;
        end
    end

    // Next-state, counter update and pulse outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_key_nxt   = r_key;
        w_snap      = 1'b0;
        enter       = 1'b0;
        change      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pe | w_pc) begin
                    w_state_nxt = ST_DEBOUNCE;
                    w_cnt_nxt   = '0;
                    w_key_nxt   = w_pc;   // change wins a simultaneous press
                end
            end
            ST_DEBOUNCE: begin
                if (!w_sel) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt = ST_ISSUE;
                    w_snap      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_ISSUE: begin
                change      = r_key;
                enter       = ~r_key;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (!(w_pe | w_pc)) begin
                    w_state_nxt = ST_COOLDOWN;
                    w_cnt_nxt   = '0;
                end
            end
            ST_COOLDOWN: begin
                if (r_cnt == HLD_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Code snapshot on accept; stored combo reload on set.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_code   <= '0;
            r_stored <= RESET_COMBO;
        end else begin
            if (w_snap) r_code   <= SW;
            if (set)    r_stored <= r_code;
        end
    end

    assign isCombo = (r_code == r_stored);
    assign busy    = (r_state != ST_IDLE);

`ifdef COMBO_ATTEMPT_CNT_EN
    logic [7:0] r_fail_cnt;

    // Consecutive wrong attempts, saturating; a correct attempt clears it.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_fail_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            if (isCombo)                  r_fail_cnt <= '0;
            else if (r_fail_cnt != 8'hFF) r_fail_cnt <= r_fail_cnt + 8'd1;
        end
    end

    assign fail_cnt = r_fail_cnt;
`endif

endmodule

// File: tb/tb_combo_key_ctrl.sv
// Directed bench for combo_key_ctrl with short debounce/holdoff counts.
module tb_combo_key_ctrl;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic [3:0] SW;
    logic       KEY_enter_n;
    logic       KEY_change_n;
    logic       set;
    wire        enter;
    wire        change;
    wire        isCombo;
    wire        busy;
`ifdef COMBO_ATTEMPT_CNT_EN
    wire [7:0]  fail_cnt;
`endif

    int   n_chk      = 0;
    int   n_fail     = 0;
    int   enter_cnt  = 0;
    int   change_cnt = 0;
    int   both_cnt   = 0;
    logic pulse_combo = 1'b0;

    combo_key_ctrl #(
        .DEBOUNCE_CYC (4),
        .HOLDOFF_CYC  (2)
    ) dut (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .SW           (SW),
        .KEY_enter_n  (KEY_enter_n),
        .KEY_change_n (KEY_change_n),
        .set          (set),
        .enter        (enter),
        .change       (change),
        .isCombo      (isCombo),
        .busy         (busy)
`ifdef COMBO_ATTEMPT_CNT_EN
        ,.fail_cnt    (fail_cnt)
`endif
    );

    always #5 Clock = ~Clock;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge Clock) begin
        if (enter)  begin enter_cnt++;  pulse_combo = isCombo; end
        if (change) begin change_cnt++; pulse_combo = isCombo; end
        if (enter && change) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60 && busy; i++) tick(1);
        chk(tag, busy, 0);
    endtask

    // sel: 0 = enter, 1 = change, 2 = both together
    task automatic press(input int sel, input int n);
        KEY_enter_n  = !(sel == 0 || sel == 2);
        KEY_change_n = !(sel == 1 || sel == 2);
        tick(n);
        KEY_enter_n  = 1'b1;
        KEY_change_n = 1'b1;
        tick(6);
    endtask

    initial begin
        int e0;
        int c0;
        Resetn = 1'b0; SW = 4'b0000; set = 1'b0;
        KEY_enter_n = 1'b1; KEY_change_n = 1'b1;
        tick(3);
        chk("rst_enter",   enter,   0);
        chk("rst_change",  change,  0);
        chk("rst_busy",    busy,    0);
        chk("rst_iscombo", isCombo, 0);   // code 0000 vs stored 0110
        Resetn = 1'b1;
        tick(2);

        // 1: matching code gives one enter pulse with isCombo high
        e0 = enter_cnt; c0 = change_cnt;
        SW = 4'b0110;
        press(0, 8);
        wait_idle("t1_idle");
        chk("t1_enter_cnt",  enter_cnt - e0,  1);
        chk("t1_change_cnt", change_cnt - c0, 0);
        chk("t1_combo",      pulse_combo,     1);

        // 2: wrong code, long hold -> single pulse, isCombo low
        e0 = enter_cnt;
        SW = 4'b1010;
        KEY_enter_n = 1'b0;
        tick(20);
        chk("t2_busy_held", busy, 1);
        KEY_enter_n = 1'b1;
        tick(6);
        wait_idle("t2_idle");
        chk("t2_enter_cnt", enter_cnt - e0, 1);
        chk("t2_combo",     pulse_combo,    0);

        // 3: short glitch on change is rejected
        e0 = enter_cnt; c0 = change_cnt;
        press(1, 2);
        wait_idle("t3_idle");
        chk("t3_change_cnt", change_cnt - c0, 0);
        chk("t3_enter_cnt",  enter_cnt - e0,  0);

        // 4: both keys at once -> change only
        e0 = enter_cnt; c0 = change_cnt;
        press(2, 8);
        wait_idle("t4_idle");
        chk("t4_change_cnt", change_cnt - c0, 1);
        chk("t4_enter_cnt",  enter_cnt - e0,  0);

        // 5: load new combo 1100 via set, then verify it matches
        c0 = change_cnt;
        SW = 4'b0110;
        press(1, 8);
        wait_idle("t5a_idle");
        chk("t5_change_cnt", change_cnt - c0, 1);
        chk("t5_change_combo", pulse_combo, 1);
        e0 = enter_cnt;
        SW = 4'b1100;
        press(0, 8);
        wait_idle("t5b_idle");
        chk("t5_enter1_combo", pulse_combo, 0);
        chk("t5_pre_set",      isCombo,     0);
        set = 1'b1;
        tick(1);
        set = 1'b0;
        chk("t5_post_set", isCombo, 1);
        press(0, 8);
        wait_idle("t5c_idle");
        chk("t5_enter_cnt",   enter_cnt - e0, 2);
        chk("t5_enter2_combo", pulse_combo,   1);

        // 6: reset during debounce discards the press and restores 0110
        e0 = enter_cnt;
        SW = 4'b0110;
        KEY_enter_n = 1'b0;
        tick(4);
        chk("t6_busy_deb", busy, 1);
        Resetn = 1'b0;
        KEY_enter_n = 1'b1;
        tick(1);
        chk("t6_busy_rst", busy, 0);
        Resetn = 1'b1;
        tick(10);
        chk("t6_no_pulse", enter_cnt - e0, 0);
        chk("t6_code_clr", isCombo, 0);
        press(0, 8);
        wait_idle("t6_idle");
        chk("t6_enter_cnt", enter_cnt - e0, 1);
        chk("t6_combo",     pulse_combo,    1);

        chk("never_both", both_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
